serial_add_sequencer: RTL and testbench
=======================================

SERIAL_ADD_SEQUENCER -- requirements
Module: serial_add_sequencer

Interface
REQ-001 Parameter NIBBLES, default 4: number of 4-bit slices per operand; operand width W = 4*NIBBLES; legal range 1..16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start_valid  input  1  requester presents an operation.
REQ-005 start_ready  output  1  block can accept an operation; high only in IDLE.
REQ-006 a  input  W  operand A, sampled at acceptance only.
REQ-007 b  input  W  operand B, sampled at acceptance only.
REQ-008 cin  input  1  carry-in for add, sampled at acceptance; ignored when sub=1.
REQ-009 sub  input  1  0 = A+B+cin; 1 = A+~B+1 (A-B); sampled at acceptance.
REQ-010 result  output  W  sum/difference, registered.
REQ-011 cout  output  1  carry out of bit W-1 (for sub: 1 = no borrow).
REQ-012 overflow  output  1  two's-complement signed overflow of the W-bit operation.
REQ-013 res_valid  output  1  result/cout/overflow valid.
REQ-014 res_ready  input  1  consumer accepts the result.
REQ-015 busy  output  1  high in ADD and DONE.

Function
REQ-016 The block SHALL compute the W-bit result with one shared 4-bit add slice (nibble + nibble + carry -> 4-bit sum + carry), one nibble per clock, LSB nibble first.
REQ-017 States: IDLE, ADD, DONE; IDLE -> ADD on start_valid && start_ready; ADD -> DONE after the NIBBLES-th slice; DONE -> IDLE on res_valid && res_ready.
REQ-018 On acceptance the block SHALL latch a, b (inverted when sub=1), the carry register (= sub ? 1 : cin), clear the nibble index to 0, and clear res_valid.
REQ-019 Each ADD cycle SHALL write slice sum to result[4i+3:4i], load the slice carry-out into the carry register, and increment index i.
REQ-020 Latency: acceptance at edge T0; slices at edges T1..TNIBBLES; res_valid SHALL be high from the cycle after edge TNIBBLES (NIBBLES cycles after accept).
REQ-021 cout SHALL equal the final slice carry-out; overflow SHALL be 1 iff MSB(A) == MSB(B') and MSB(result) != MSB(A), with B' the post-inversion operand.
REQ-022 In DONE with res_ready=0, result, cout, overflow, res_valid SHALL hold stable.
REQ-023 DONE -> IDLE handshake SHALL drop res_valid next cycle; start_ready SHALL NOT be asserted in the handshake cycle (no same-cycle turnaround).
REQ-024 start_valid while busy SHALL be ignored; input changes after acceptance SHALL NOT affect the in-flight operation.
REQ-025 Arithmetic wraps modulo 2^W; no saturation.
REQ-026 result bits SHALL retain the previous operation's value until overwritten slice by slice; consumers use them only while res_valid=1.
REQ-027 NIBBLES=1 SHALL take one ADD cycle and otherwise behave identically.

Reset
REQ-028 rst_n low SHALL immediately force IDLE: result=0, cout=0, overflow=0, res_valid=0, busy=0, start_ready=1, index=0, carry register=0.
REQ-029 Reset asserted mid-ADD or in DONE SHALL discard the operation; no partial result SHALL be presented after release.
REQ-030 First acceptance SHALL be possible on the first rising edge after rst_n deasserts.

Verification (NIBBLES=4)
REQ-031 a=0x1234, b=0x4321, cin=0, sub=0 -> result=0x5555, cout=0, overflow=0, res_valid high exactly 4 cycles after accept.
REQ-032 a=0xFFFF, b=0x0001, cin=0 -> result=0x0000, cout=1, overflow=0 (full carry ripple through all slices).
REQ-033 a=0x7FFF, b=0x0000, cin=1 -> result=0x8000, cout=0, overflow=1.
REQ-034 a=0x0005, b=0x0007, sub=1, cin=1 -> result=0xFFFE, cout=0, overflow=0 (cin ignored).
REQ-035 Hold res_ready=0 for 3 cycles in DONE while toggling a/b/start_valid -> outputs unchanged, start_ready=0; res_ready=1 -> res_valid=0 next cycle, start_ready=1 following cycle.
REQ-036 Assert rst_n=0 after second ADD slice -> all outputs at reset values asynchronously; after release, new op 0x0001+0x0001 -> 0x0002 with normal latency.

Source files
------------

// File: rtl/serial_add_sequencer.sv
// Serial add/subtract sequencer: one shared 4-bit adder slice processes one
// nibble per clock, LSB nibble first, and presents a registered result with
// carry-out and signed overflow under a valid/ready handshake.
module serial_add_sequencer #(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start_valid,
   output logic                   start_ready,
   input  logic [4*NIBBLES-1:0]   a,
   input  logic [4*NIBBLES-1:0]   b,
   input  logic                   cin,
   input  logic                   sub,
   output logic [4*NIBBLES-1:0]   result,
   output logic                   cout,
   output logic                   overflow,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic                   busy
);

   localparam int W  = 4 * NIBBLES;
   localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ADD,
      S_DONE
   } state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   a_q, a_d;
   logic [W-1:0]   b_q, b_d;
   logic           carry_q, carry_d;
   logic [IW-1:0]  idx_q, idx_d;
   logic [W-1:0]   result_q, result_d;
   logic           cout_q, cout_d;
   logic           overflow_q, overflow_d;
   logic           res_valid_q, res_valid_d;
   logic           start_ready_q, start_ready_d;
   logic           busy_q, busy_d;

   logic [3:0]     a_nib;
   logic [3:0]     b_nib;
   logic [3:0]     slice_sum;
   logic           slice_carry;

   // Shared slice adder on the nibble selected by the index, plus next-state decode
   always_comb begin
      state_d       = state_q;
      a_d           = a_q;
      b_d           = b_q;
      carry_d       = carry_q;
      idx_d         = idx_q;
      result_d      = result_q;
      cout_d        = cout_q;
      overflow_d    = overflow_q;
      res_valid_d   = res_valid_q;

      a_nib                    = a_q[{idx_q, 2'b00} +: 4];
      b_nib                    = b_q[{idx_q, 2'b00} +: 4];
      {slice_carry, slice_sum} = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_q};

      case (state_q)
         S_IDLE: begin
            if (start_valid) begin
               state_d     = S_ADD;
               a_d         = a;
               b_d         = sub ? ~b : b;
               carry_d     = sub ? 1'b1 : cin;
               idx_d       = '0;
               res_valid_d = 1'b0;
            end
         end
         S_ADD: begin
            result_d[{idx_q, 2'b00} +: 4] = slice_sum;
            carry_d                       = slice_carry;
            if (idx_q == LAST_IDX) begin
               state_d     = S_DONE;
               idx_d       = '0;
               cout_d      = slice_carry;
               overflow_d  = (a_q[W-1] == b_q[W-1]) && (slice_sum[3] != a_q[W-1]);
               res_valid_d = 1'b1;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         S_DONE: begin
            if (res_ready) begin
               state_d     = S_IDLE;
               res_valid_d = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      start_ready_d = (state_d == S_IDLE);
      busy_d        = (state_d != S_IDLE);
   end

   // State and datapath registers; reset discards any operation in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         a_q           <= '0;
         b_q           <= '0;
         carry_q       <= 1'b0;
         idx_q         <= '0;
         result_q      <= '0;
         cout_q        <= 1'b0;
         overflow_q    <= 1'b0;
         res_valid_q   <= 1'b0;
         start_ready_q <= 1'b1;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         a_q           <= a_d;
         b_q           <= b_d;
         carry_q       <= carry_d;
         idx_q         <= idx_d;
         result_q      <= result_d;
         cout_q        <= cout_d;
         overflow_q    <= overflow_d;
         res_valid_q   <= res_valid_d;
         start_ready_q <= start_ready_d;
         busy_q        <= busy_d;
      end
   end

   assign start_ready = start_ready_q;
   assign busy        = busy_q;
   assign result      = result_q;
   assign cout        = cout_q;
   assign overflow    = overflow_q;
   assign res_valid   = res_valid_q;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Self-checking bench for serial_add_sequencer: directed cases, handshake
// hold, mid-operation reset and randomized operations against an
// arithmetic reference model.
module tb_serial_add_sequencer;

   localparam int NIBBLES = 4;
   localparam int W       = 4 * NIBBLES;

   logic          clk;
   logic          rst_n;
   logic          start_valid;
   logic          start_ready;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          cin;
   logic          sub;
   logic [W-1:0]  result;
   logic          cout;
   logic          overflow;
   logic          res_valid;
   logic          res_ready;
   logic          busy;

   int checks = 0;
   int errors = 0;

   serial_add_sequencer #(.NIBBLES(NIBBLES)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .a           (a),
      .b           (b),
      .cin         (cin),
      .sub         (sub),
      .result      (result),
      .cout        (cout),
      .overflow    (overflow),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .busy        (busy)
   );

   // Free-running clock, 10 time-unit period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: returns {cout, overflow, result} from integer arithmetic
   function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic c, input logic s);
      longint ux, uy, sx, sy, tot_u, tot_s;
      logic   co, ov;
      logic [W-1:0] res;
      ux = longint'(x);
      uy = longint'(y);
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      if (!s) begin
         tot_u = ux + uy + longint'(c);
         tot_s = sx + sy + longint'(c);
         co    = (tot_u >= (64'sd1 <<< W));
      end else begin
         tot_u = ux - uy;
         tot_s = sx - sy;
         co    = (ux >= uy);
      end
      res = tot_u[W-1:0];
      ov  = (tot_s > ((64'sd1 <<< (W-1)) - 1)) || (tot_s < -(64'sd1 <<< (W-1)));
      return {co, ov, res};
   endfunction

   // Present one operation at a falling edge and wait (bounded) for res_valid
   task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic icin, input logic isub,
                        output logic ready_seen, output int lat);
      ready_seen  = start_ready;
      start_valid = 1'b1;
      a           = ia;
      b           = ib;
      cin         = icin;
      sub         = isub;
      res_ready   = 1'b0;
      @(negedge clk);
      start_valid = 1'b0;
      a           = W'($urandom);
      b           = W'($urandom);
      cin         = 1'($urandom);
      sub         = 1'($urandom);
      lat         = 0;
      while (res_valid !== 1'b1 && lat < 64) begin
         @(negedge clk);
         lat++;
         start_valid = 1'($urandom_range(0, 1));
         a           = W'($urandom);
         b           = W'($urandom);
      end
      start_valid = 1'b0;
   endtask

   // Complete the result handshake in one cycle
   task automatic finish_op();
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
   endtask

   task automatic test_reset();
      logic rs;
      int   lat;
      rst_n       = 1'b0;
      start_valid = 1'b0;
      res_ready   = 1'b0;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({result, cout, overflow, res_valid, busy, start_ready} !== {16'h0000, 5'b00001}) begin
         errors++;
         $display("[TB] FAIL reset_state got %h expected %h",
                  {result, cout, overflow, res_valid, busy, start_ready}, {16'h0000, 5'b00001});
      end
      rst_n = 1'b1;
      do_op(16'h1234, 16'h4321, 1'b0, 1'b0, rs, lat);
      checks++;
      if (rs !== 1'b1) begin
         errors++;
         $display("[TB] FAIL first_accept_ready got %b expected 1", rs);
      end
      checks++;
      if (lat !== NIBBLES) begin
         errors++;
         $display("[TB] FAIL first_latency got %0d expected %0d", lat, NIBBLES);
      end
      checks++;
      if ({cout, overflow, result} !== {2'b00, 16'h5555}) begin
         errors++;
         $display("[TB] FAIL first_result got %h expected %h", {cout, overflow, result}, {2'b00, 16'h5555});
      end
      finish_op();
   endtask

   task automatic test_directed();
      logic [W-1:0] ta [4] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0005};
      logic [W-1:0] tb [4] = '{16'h4321, 16'h0001, 16'h0000, 16'h0007};
      logic         tc [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      logic         ts [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      logic [W-1:0] er [4] = '{16'h5555, 16'h0000, 16'h8000, 16'hFFFE};
      logic         ec [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
      logic         eo [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
      logic rs;
      int   lat;
      for (int i = 0; i < 4; i++) begin
         do_op(ta[i], tb[i], tc[i], ts[i], rs, lat);
         checks++;
         if (lat !== NIBBLES) begin
            errors++;
            $display("[TB] FAIL directed_latency[%0d] got %0d expected %0d", i, lat, NIBBLES);
         end
         checks++;
         if ({cout, overflow, result} !== {ec[i], eo[i], er[i]}) begin
            errors++;
            $display("[TB] FAIL directed_result[%0d] got %h expected %h",
                     i, {cout, overflow, result}, {ec[i], eo[i], er[i]});
         end
         finish_op();
      end
   endtask

   task automatic test_hold();
      logic [W-1:0] xa, xb;
      logic         xc, xs, rs;
      logic [W+1:0] exp;
      int           lat;
      xa  = W'($urandom);
      xb  = W'($urandom);
      xc  = 1'($urandom);
      xs  = 1'($urandom);
      exp = model(xa, xb, xc, xs);
      do_op(xa, xb, xc, xs, rs, lat);
      for (int i = 0; i < 3; i++) begin
         start_valid = ~start_valid;
         a           = W'($urandom);
         b           = W'($urandom);
         @(negedge clk);
         checks++;
         if ({cout, overflow, result, res_valid, start_ready} !== {exp, 1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL hold_stable[%0d] got %h expected %h",
                     i, {cout, overflow, result, res_valid, start_ready}, {exp, 1'b1, 1'b0});
         end
      end
      start_valid = 1'b0;
      res_ready   = 1'b1;
      checks++;
      if (start_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL handshake_cycle_ready got %b expected 0", start_ready);
      end
      @(negedge clk);
      res_ready = 1'b0;
      checks++;
      if ({res_valid, start_ready, busy} !== 3'b010) begin
         errors++;
         $display("[TB] FAIL after_handshake got %b expected 010", {res_valid, start_ready, busy});
      end
   endtask

   task automatic test_mid_reset();
      logic rs;
      int   lat;
      start_valid = 1'b1;
      a           = W'($urandom);
      b           = W'($urandom);
      cin         = 1'b1;
      sub         = 1'b0;
      @(negedge clk);
      start_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({result, cout, overflow, res_valid, busy, start_ready} !== {16'h0000, 5'b00001}) begin
         errors++;
         $display("[TB] FAIL mid_reset_state got %h expected %h",
                  {result, cout, overflow, res_valid, busy, start_ready}, {16'h0000, 5'b00001});
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checks++;
         if ({res_valid, busy} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL no_partial_result[%0d] got %b expected 00", i, {res_valid, busy});
         end
      end
      do_op(16'h0001, 16'h0001, 1'b0, 1'b0, rs, lat);
      checks++;
      if (lat !== NIBBLES || {cout, overflow, result} !== {2'b00, 16'h0002}) begin
         errors++;
         $display("[TB] FAIL post_reset_op got lat %0d value %h expected lat %0d value %h",
                  lat, {cout, overflow, result}, NIBBLES, {2'b00, 16'h0002});
      end
      finish_op();
   endtask

   task automatic test_random();
      logic [W-1:0] xa, xb;
      logic         xc, xs, rs;
      logic [W+1:0] exp;
      int           lat;
      for (int i = 0; i < 40; i++) begin
         xa = W'($urandom);
         xb = W'($urandom);
         if (i % 8 == 0) xb = W'(0) - xa;
         xc  = 1'($urandom);
         xs  = 1'($urandom);
         exp = model(xa, xb, xc, xs);
         do_op(xa, xb, xc, xs, rs, lat);
         checks++;
         if (lat !== NIBBLES || {cout, overflow, result} !== exp) begin
            errors++;
            $display("[TB] FAIL random[%0d] a=%h b=%h cin=%b sub=%b got lat %0d value %h expected lat %0d value %h",
                     i, xa, xb, xc, xs, lat, {cout, overflow, result}, NIBBLES, exp);
         end
         finish_op();
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] xa, xb;
      logic         xc, xs, rs;
      logic [W+1:0] exp;
      int           lat;
      for (int i = 0; i < 6; i++) begin
         xa  = W'($urandom);
         xb  = W'($urandom);
         xc  = 1'($urandom);
         xs  = 1'($urandom);
         exp = model(xa, xb, xc, xs);
         do_op(xa, xb, xc, xs, rs, lat);
         checks++;
         if (rs !== 1'b1 || lat !== NIBBLES || {cout, overflow, result} !== exp) begin
            errors++;
            $display("[TB] FAIL back_to_back[%0d] got ready %b lat %0d value %h expected ready 1 lat %0d value %h",
                     i, rs, lat, {cout, overflow, result}, NIBBLES, exp);
         end
         finish_op();
      end
   endtask

   // Run every scenario in order, then report
   initial begin
      test_reset();
      test_directed();
      test_hold();
      test_mid_reset();
      test_random();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
